ahb_sram_slave: RTL

AHB-Lite responder that terminates the 64-bit bus driven by the CPU bus interface, covering cache line fills, uncached single accesses and write-through. It maps a window of the physical address space onto a single-port synchronous SRAM with 1-cycle read latency. Single reads and writes complete with zero wait states. A read whose address phase coincides with a write data phase costs one wait state. Illegal transfers get the two-cycle AHB ERROR response.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_be_gen.sv | 32 +++
 rtl/ahb_sram_slave.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type used by the SRAM responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_STALL,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

endpackage

// File: rtl/ahb_be_gen.sv
// Byte-lane enables and alignment check for a 64-bit AHB data bus.
module ahb_be_gen
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [2:0] addr_lo,
  output logic [7:0] be,
  output logic       misaligned
);

  always_comb begin
    be         = 8'h00;
    misaligned = 1'b0;
    case (size)
      HSIZE_BYTE: be = 8'h01 << addr_lo;
      HSIZE_HALF: begin
        be         = 8'h03 << addr_lo;
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        be         = 8'h0F << addr_lo;
        misaligned = |addr_lo[1:0];
      end
      HSIZE_DWORD: begin
        be         = 8'hFF;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder mapping an address window onto a single-port SRAM with
// 1-cycle read latency; reads colliding with a write data phase stall one cycle.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int          ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  hreset_n,
  input  logic                  hsel,
  input  logic [63:0]           haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [1:0]            htrans,
  input  logic                  hmastlock,
  input  logic [63:0]           hwdata,
  input  logic                  hready_in,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [63:0]           hrdata,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [7:0]            sram_be,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [63:0]           sram_wdata,
  input  logic [63:0]           sram_rdata
);

  localparam logic [63:0] WIN_BYTES = 64'd1 << (ADDR_WIDTH + 3);
  localparam logic [63:0] END_ADDR  = BASE_ADDR + WIN_BYTES;

  ahb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            be_q, be_d;

  logic [63:0]           offset;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [7:0]            be_req;
  logic                  misaligned;
  logic                  accept;
  logic                  illegal;
  logic                  unused_inputs;

  assign offset    = haddr - BASE_ADDR;
  assign word_addr = offset[ADDR_WIDTH+2:3];

  ahb_be_gen u_be_gen (
    .size       (hsize),
    .addr_lo    (haddr[2:0]),
    .be         (be_req),
    .misaligned (misaligned)
  );

  // Gating with reset keeps the SRAM port quiet while reset is held.
  assign accept  = hreset_n & hsel & hready_in & htrans[1];
  assign illegal = (hsize > HSIZE_DWORD) | misaligned
                 | (haddr < BASE_ADDR) | (haddr >= END_ADDR);

  assign unused_inputs = ^{offset[63:ADDR_WIDTH+3], offset[2:0], hburst, hprot, hmastlock};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    case (state_q)
      ST_RD_STALL: state_d = ST_RD;
      ST_ERR1:     state_d = ST_ERR2;
      default: begin
        if (hready_in) begin
          if (!accept) begin
            state_d = ST_IDLE;
          end else if (illegal) begin
            state_d = ST_ERR1;
          end else if (hwrite) begin
            state_d = ST_WR;
            addr_d  = word_addr;
            be_d    = be_req;
          end else if (state_q == ST_WR) begin
            state_d = ST_RD_STALL;
            addr_d  = word_addr;
            be_d    = be_req;
          end else begin
            state_d = ST_RD;
          end
        end
      end
    endcase
  end

  always_comb begin
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    hrdata     = '0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      ST_WR: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_be    = be_q;
        sram_addr  = addr_q;
        sram_wdata = hwdata;
      end
      ST_RD_STALL: begin
        hreadyout = 1'b0;
        sram_ce   = 1'b1;
        sram_be   = be_q;
        sram_addr = addr_q;
      end
      ST_RD:   hrdata = sram_rdata;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
    // Address-phase read issue; in WR the port is busy so the read is deferred.
    if ((state_q inside {ST_IDLE, ST_RD, ST_ERR2}) && accept && !illegal && !hwrite) begin
      sram_ce   = 1'b1;
      sram_be   = be_req;
      sram_addr = word_addr;
    end
  end

  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

endmodule
